// File: rtl/axil_arb_pkg.sv
// Shared types for the AXI-Lite request arbiter: FSM encoding, AXI response
// codes and bus widths.
package axil_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   // SLVERR and DECERR both have the upper bit set.
   function automatic logic resp_is_err(input axi_resp_e resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past ptr and wraps,
// returning a one-hot grant and its index.
module rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int PTR_W = 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [PTR_W-1:0] grant_idx
);

   logic found;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment, otherwise synthesis infers a latch.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int off = 1; off <= NREQ; off++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (j == (int'(ptr) + off) % NREQ)) begin
               found     = 1'b1;
               grant[j]  = 1'b1;
               grant_idx = PTR_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/axil_req_arb.sv
// Round-robin arbiter funnelling NREQ simple requesters onto one AXI-Lite
// master port. Define AXIL_ARB_TIMEOUT_EN to enable the busy-timeout abort.
module axil_req_arb
   import axil_arb_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        req_ready,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic                   rsp_timeout,
   output logic [ADDR_W-1:0]      app_waddr,
   output logic [DATA_W-1:0]      app_wdata,
   output logic                   app_wen,
   output logic [ADDR_W-1:0]      app_raddr,
   output logic                   app_ren,
   input  logic [DATA_W-1:0]      app_rdata,
   input  logic                   app_wdone,
   input  logic                   app_werror,
   input  logic                   app_rdone,
   input  logic                   app_rerror
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("axil_req_arb: NREQ must be 2..8 and TIMEOUT_CYC at least 2");
   end

   arb_state_e        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, grant_idx;
   logic [NREQ-1:0]   grant, owner_q;
   logic              lat_we;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              en_q, status_done, status_err, timeout_hit, exit_busy;
   axi_resp_e         resp_d;

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Status is only honoured once the enable is actually on the bus.
   assign en_q = app_wen | app_ren;

   always_comb begin
      status_done = lat_we ? (app_wdone | app_werror) : (app_rdone | app_rerror);
      status_err  = lat_we ? app_werror : app_rerror;
      exit_busy   = (state_q == ST_BUSY) && en_q && (status_done || timeout_hit);
      resp_d      = (status_err || (timeout_hit && !status_done)) ? RESP_SLVERR : RESP_OKAY;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (|req_valid) state_d = ST_BUSY;
         ST_BUSY: if (exit_busy)  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= ST_IDLE;
         ptr_q     <= PTR_W'(NREQ - 1);
         owner_q   <= '0;
         lat_we    <= 1'b0;
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         app_waddr <= '0;
         app_wdata <= '0;
         app_raddr <= '0;
         app_wen   <= 1'b0;
         app_ren   <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_ready <= '0;
         rsp_valid <= '0;
         case (state_q)
            ST_IDLE: begin
               app_wen <= 1'b0;
               app_ren <= 1'b0;
               if (|req_valid) begin
                  req_ready <= grant;
                  owner_q   <= grant;
                  ptr_q     <= grant_idx;
                  lat_we    <= sel_we;
                  app_waddr <= sel_addr;
                  app_raddr <= sel_addr;
                  app_wdata <= sel_wdata;
               end
            end
            ST_BUSY: begin
               app_wen <= lat_we && !exit_busy;
               app_ren <= !lat_we && !exit_busy;
               if (exit_busy) begin
                  rsp_valid <= owner_q;
                  rsp_err   <= resp_is_err(resp_d);
                  rsp_rdata <= (!lat_we && status_done) ? app_rdata : '0;
               end
            end
            default: begin
               app_wen <= 1'b0;
               app_ren <= 1'b0;
            end
         endcase
      end
   end

`ifdef AXIL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] busy_cnt;
   logic             rsp_timeout_q;

   // Counts enable-high cycles, so the abort lands after TIMEOUT_CYC of them.
   assign timeout_hit = (state_q == ST_BUSY) && en_q &&
                        (busy_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge aclk) begin
      if (areset) begin
         busy_cnt      <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && |req_valid) begin
            busy_cnt <= '0;
         end else if (state_q == ST_BUSY && en_q) begin
            busy_cnt <= busy_cnt + 1'b1;
         end
         if (exit_busy) begin
            rsp_timeout_q <= timeout_hit && !status_done;
         end
      end
   end

   assign rsp_timeout = rsp_timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axil_req_arb.sv
// Directed bench for axil_req_arb with a response scoreboard; the timeout
// scenario runs when AXIL_ARB_TIMEOUT_EN is defined.
module tb_axil_req_arb;

   localparam int NREQ = 2;

   typedef struct {
      logic [NREQ-1:0] owner;
      logic [31:0]     rdata;
      logic            err;
      logic            tmo;
   } exp_t;

   logic                 aclk;
   logic                 areset;
   logic [NREQ-1:0]      req_valid, req_we, req_ready, rsp_valid;
   logic [NREQ*32-1:0]   req_addr, req_wdata;
   logic [31:0]          rsp_rdata, app_waddr, app_wdata, app_raddr, app_rdata;
   logic                 rsp_err, rsp_timeout, app_wen, app_ren;
   logic                 app_wdone, app_werror, app_rdone, app_rerror;

   exp_t        sb[$];
   int          n_tests, n_fail, n_rsp_seen, n_rsp_exp, rr_last;
   logic [31:0] tb_addr[NREQ];
   logic [31:0] tb_wdata[NREQ];

   axil_req_arb #(
      .NREQ        (NREQ),
      .TIMEOUT_CYC (16)
   ) dut (
      .aclk        (aclk),
      .areset      (areset),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .app_waddr   (app_waddr),
      .app_wdata   (app_wdata),
      .app_wen     (app_wen),
      .app_raddr   (app_raddr),
      .app_ren     (app_ren),
      .app_rdata   (app_rdata),
      .app_wdone   (app_wdone),
      .app_werror  (app_werror),
      .app_rdone   (app_rdone),
      .app_rerror  (app_rerror)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   always @(negedge aclk) begin
      if (!areset && rsp_valid != '0) n_rsp_seen++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
      for (int off = 1; off <= NREQ; off++) begin
         int i = (last + off) % NREQ;
         if (v[i]) return i;
      end
      return 0;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] oh;
      oh    = '0;
      oh[i] = 1'b1;
      return oh;
   endfunction

   task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
      req_we[i]            = we;
      req_addr[i*32 +: 32]  = a;
      req_wdata[i*32 +: 32] = d;
      tb_addr[i]           = a;
      tb_wdata[i]          = d;
   endtask

   task automatic pop_check();
      exp_t e;
      check("sb_depth", sb.size(), 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         n_rsp_exp++;
         check("rsp_valid", rsp_valid, e.owner);
         check("rsp_rdata", rsp_rdata, e.rdata);
         check("rsp_err", rsp_err, e.err);
         check("rsp_timeout", rsp_timeout, e.tmo);
      end
   endtask

   // Raise mask, wait for the accept pulse, compare against the RR model.
   task automatic grant_step(input logic [NREQ-1:0] mask, input bit hold, output int gidx);
      int exp_i;
      bit seen;
      req_valid = mask;
      exp_i     = rr_pick(mask, rr_last);
      seen      = 1'b0;
      for (int t = 0; t < 32 && !seen; t++) begin
         @(negedge aclk);
         if (req_ready != '0) seen = 1'b1;
      end
      check("grant_seen", seen, 1);
      check("grant", req_ready, onehot(exp_i));
      check("en_low_c0", {app_wen, app_ren}, 2'b00);
      rr_last = exp_i;
      gidx    = exp_i;
      if (!hold) req_valid[exp_i] = 1'b0;
   endtask

   // Master side: keep enable for k cycles, return status in cycle k.
   task automatic serve(input int owner, input int k, input bit st_done, input bit st_err,
                        input logic [31:0] rdata);
      logic we;
      int   hi;
      exp_t e;
      we = req_we[owner];
      hi = 0;
      for (int c = 1; c <= k; c++) begin
         @(negedge aclk);
         if (we ? (app_wen === 1'b1 && app_ren === 1'b0) : (app_ren === 1'b1 && app_wen === 1'b0))
            hi++;
         if (c == k) begin
            app_wdone  = we & st_done;
            app_werror = we & st_err;
            app_rdone  = !we & st_done;
            app_rerror = !we & st_err;
            app_rdata  = rdata;
         end
      end
      check("en_cycles", hi, k);
      check("app_addr", we ? app_waddr : app_raddr, tb_addr[owner]);
      if (we) check("app_wdata", app_wdata, tb_wdata[owner]);
      e.owner = onehot(owner);
      e.rdata = we ? 32'h0 : rdata;
      e.err   = st_err;
      e.tmo   = 1'b0;
      sb.push_back(e);
      @(negedge aclk);
      {app_wdone, app_werror, app_rdone, app_rerror} = '0;
      app_rdata = 32'h5555_AAAA;
      check("en_low_done", {app_wen, app_ren}, 2'b00);
      pop_check();
      @(negedge aclk);
      check("rsp_one_cycle", rsp_valid, '0);
      check("en_low_gap", {app_wen, app_ren}, 2'b00);
   endtask

   initial begin
      int   g, hi, cyc, pulses;
      bit   seen;
      exp_t e;
      n_tests = 0; n_fail = 0; n_rsp_exp = 0; rr_last = NREQ - 1;
      areset = 1'b1;
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      app_rdata = '0; app_wdone = 1'b0; app_werror = 1'b0; app_rdone = 1'b0; app_rerror = 1'b0;
      repeat (3) @(negedge aclk);

      check("rst_req_ready", req_ready, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_enables", {app_wen, app_ren}, 2'b00);
      check("rst_addr_data", {app_waddr, app_raddr}, 64'h0);
      check("rst_wdata", app_wdata, 32'h0);
      check("rst_rsp", {rsp_rdata, rsp_err, rsp_timeout}, 34'h0);
      areset = 1'b0;

      // Single write, three enable cycles.
      set_req(0, 1'b1, 32'h10, 32'hA5A5_A5A5);
      grant_step(2'b01, 1'b0, g);
      serve(g, 3, 1'b1, 1'b0, 32'h0);

      // Single read on requester 1.
      set_req(1, 1'b0, 32'h20, 32'h0);
      grant_step(2'b10, 1'b0, g);
      serve(g, 1, 1'b1, 1'b0, 32'hDEAD_BEEF);

      // Both requesters held valid: grants must alternate 0,1,0,1.
      set_req(0, 1'b1, 32'h30, 32'h1111_2222);
      set_req(1, 1'b0, 32'h34, 32'h0);
      for (int i = 0; i < 4; i++) begin
         grant_step(2'b11, 1'b1, g);
         check("rr_order", g, i % 2);
         serve(g, 1 + i, 1'b1, 1'b0, 32'hC0DE_0000 + i);
      end
      req_valid = '0;

      // Write where done and error arrive together: error wins.
      set_req(0, 1'b1, 32'h44, 32'h0000_0BAD);
      grant_step(2'b01, 1'b0, g);
      serve(g, 2, 1'b1, 1'b1, 32'h0);

      set_req(0, 1'b0, 32'h48, 32'h0);
      app_rdata = 32'h1234_5678;
`ifdef AXIL_ARB_TIMEOUT_EN
      // No status ever returned: abort after 16 enable cycles.
      grant_step(2'b01, 1'b0, g);
      e.owner = onehot(0); e.rdata = 32'h0; e.err = 1'b1; e.tmo = 1'b1;
      sb.push_back(e);
      hi = 0; cyc = 0; seen = 1'b0;
      for (int t = 1; t <= 40 && !seen; t++) begin
         @(negedge aclk);
         if (app_ren === 1'b1) hi++;
         if (rsp_valid != '0) begin
            seen = 1'b1;
            cyc  = t;
         end
      end
      check("tmo_latency", cyc, 17);
      check("tmo_en_cycles", hi, 16);
      pop_check();
      @(negedge aclk);
`else
      // No timeout build: the read must wait indefinitely for status.
      grant_step(2'b01, 1'b0, g);
      e.owner = onehot(0); e.rdata = 32'hFACE_0001; e.err = 1'b0; e.tmo = 1'b0;
      sb.push_back(e);
      pulses = 0;
      for (int t = 0; t < 40; t++) begin
         @(negedge aclk);
         if (rsp_valid != '0) pulses++;
      end
      check("no_tmo_pulses", pulses, 0);
      check("no_tmo_ren_held", app_ren, 1'b1);
      app_rdone = 1'b1;
      app_rdata = 32'hFACE_0001;
      @(negedge aclk);
      app_rdone = 1'b0;
      pop_check();
      @(negedge aclk);
`endif

      // Reset in the middle of a read: enable drops, no response, pointer resets.
      set_req(0, 1'b0, 32'h60, 32'h0);
      grant_step(2'b01, 1'b0, g);
      repeat (2) @(negedge aclk);
      check("rst_pre_ren", app_ren, 1'b1);
      areset = 1'b1;
      @(negedge aclk);
      check("rst_mid_ren", app_ren, 1'b0);
      check("rst_mid_rsp", rsp_valid, '0);
      check("rst_mid_raddr", app_raddr, 32'h0);
      areset  = 1'b0;
      rr_last = NREQ - 1;
      repeat (3) @(negedge aclk);
      check("rst_post_rsp", rsp_valid, '0);

      set_req(0, 1'b1, 32'h70, 32'h7777_0000);
      set_req(1, 1'b0, 32'h74, 32'h0);
      grant_step(2'b11, 1'b0, g);
      check("rst_first_owner", g, 0);
      serve(g, 2, 1'b1, 1'b0, 32'h0);
      grant_step(2'b10, 1'b0, g);
      serve(g, 1, 1'b1, 1'b0, 32'h0BAD_CAFE);

      repeat (2) @(negedge aclk);
      #1;
      check("rsp_count", n_rsp_seen, n_rsp_exp);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
